// File: rtl/ecpri_pkg.sv
// eCPRI shared definitions: parser states, protocol constants, common header layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ecpri_pkg;

    localparam logic [15:0] ECPRI_ETHERTYPE = 16'hAEFE;
    localparam logic [3:0]  ECPRI_REV       = 4'd1;

    localparam logic [7:0]  MSG_IQ      = 8'd0;
    localparam logic [7:0]  MSG_BIT_SEQ = 8'd1;
    localparam logic [7:0]  MSG_RTC     = 8'd2;

    localparam logic [15:0] ETH_HDR_LAST   = 16'd13;
    localparam logic [15:0] SHORT_HDR_LAST = 16'd3;
    localparam logic [15:0] IQ_HDR_BYTES   = 16'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ETH_HDR,
        ST_ECPRI_HDR,
        ST_IQ_HDR,
        ST_PAYLOAD,
        ST_DROP
    } rx_state_e;

    typedef struct packed {
        logic [3:0]  revision;
        logic [2:0]  reserved;
        logic        concat;
        logic [7:0]  msg_type;
        logic [15:0] payload_size;
    } ecpri_common_hdr_t;

    // IQ data, bit sequence and real-time control carry the 4-byte PC_ID/SEQ_ID block.
    function automatic logic has_iq_hdr(input logic [7:0] msg_type);
        return msg_type <= MSG_RTC;
    endfunction

endpackage

// File: rtl/ecpri_rx_stats.sv
// Good/bad frame counters, bumped once per completed frame; both wrap at 2^32.
// Latency: count reflects a frame the cycle after its frm_done pulse.
// Backpressure: none; observes the frame-done pulse only.
module ecpri_rx_stats (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frm_done,
    input  logic        frm_err,
    output logic [31:0] stat_good,
    output logic [31:0] stat_bad
);

    logic [31:0] good_q, good_d;
    logic [31:0] bad_q,  bad_d;

    always_comb begin
        good_d = good_q;
        bad_d  = bad_q;
        if (frm_done) begin
            if (frm_err) bad_d  = bad_q + 32'd1;
            else         good_d = good_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_q <= 32'd0;
            bad_q  <= 32'd0;
        end else begin
            good_q <= good_d;
            bad_q  <= bad_d;
        end
    end

    assign stat_good = good_q;
    assign stat_bad  = bad_q;

endmodule

// File: rtl/ecpri_rx_parser.sv
// eCPRI RX parser: checks Ethernet/eCPRI/IQ headers, publishes fields, forwards payload bytes.
// Latency: fields, payload bytes and frame status appear 1 cycle after the byte/edge that produces them.
// Backpressure: none, one byte per pkt_en cycle. ECPRI_RX_STATS_EN adds stat_good/stat_bad counters.
module ecpri_rx_parser #(
    parameter logic [15:0] ETHERTYPE = ecpri_pkg::ECPRI_ETHERTYPE,
    parameter logic [3:0]  ECPRI_REV = ecpri_pkg::ECPRI_REV
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pkt_en,
    input  logic [7:0]  pkt_data,
    output logic        hdr_valid,
    output logic [3:0]  hdr_revision,
    output logic        hdr_concat,
    output logic [7:0]  hdr_msg_type,
    output logic [15:0] hdr_payload_size,
    output logic [15:0] hdr_pc_id,
    output logic [15:0] hdr_seq_id,
    output logic        pl_valid,
    output logic [7:0]  pl_data,
    output logic        pl_sop,
    output logic        pl_eop,
    output logic        frm_done,
    output logic        err_ethertype,
    output logic        err_revision,
    output logic        err_length,
    output logic        err_short
`ifdef ECPRI_RX_STATS_EN
    ,
    output logic [31:0] stat_good,
    output logic [31:0] stat_bad
`endif
);

    import ecpri_pkg::*;

    rx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d, len_q, len_d, size_q, size_d;
    logic [15:0] pc_id_q, pc_id_d, seq_id_q, seq_id_d;
    logic [7:0]  etype_hi_q, etype_hi_d, msg_type_q, msg_type_d, pl_data_q, pl_data_d;
    logic [3:0]  rev_q, rev_d;
    logic        concat_q, concat_d, blocked_q, blocked_d;
    logic        bad_eth_q, bad_eth_d, bad_rev_q, bad_rev_d, bad_len_q, bad_len_d;
    logic        hdr_valid_q, hdr_valid_d, pl_valid_q, pl_valid_d;
    logic        pl_sop_q, pl_sop_d, pl_eop_q, pl_eop_d, frm_done_q, frm_done_d;
    logic        err_eth_q, err_eth_d, err_rev_q, err_rev_d;
    logic        err_len_q, err_len_d, err_short_q, err_short_d;

    logic        start, in_frame, fall, incomplete;
    logic        eth_last, eth_bad, ec_byte0, rev_bad, ec_last, len_bad, is_iq;
    logic        iq_last, pl_byte, pl_last;
    logic [15:0] size_now;

    assign in_frame   = pkt_en && (state_q != ST_IDLE);
    // After reset the block stays blocked until it has seen the gap before a frame.
    assign start      = pkt_en && !blocked_q && (state_q == ST_IDLE);
    assign fall       = !pkt_en && (state_q != ST_IDLE);
    assign incomplete = (state_q inside {ST_ETH_HDR, ST_ECPRI_HDR, ST_IQ_HDR, ST_PAYLOAD});
    assign eth_last   = in_frame && (state_q == ST_ETH_HDR) && (cnt_q == ETH_HDR_LAST);
    assign eth_bad    = eth_last && ({etype_hi_q, pkt_data} != ETHERTYPE);
    assign ec_byte0   = in_frame && (state_q == ST_ECPRI_HDR) && (cnt_q == 16'd0);
    assign rev_bad    = ec_byte0 && (pkt_data[7:4] != ECPRI_REV);
    assign ec_last    = in_frame && (state_q == ST_ECPRI_HDR) && (cnt_q == SHORT_HDR_LAST);
    assign size_now   = {size_q[15:8], pkt_data};
    assign is_iq      = has_iq_hdr(msg_type_q);
    assign len_bad    = ec_last && is_iq && (size_now < IQ_HDR_BYTES);
    assign iq_last    = in_frame && (state_q == ST_IQ_HDR) && (cnt_q == SHORT_HDR_LAST);
    assign pl_byte    = in_frame && (state_q == ST_PAYLOAD);
    assign pl_last    = pl_byte && (cnt_q == len_q - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (start) state_d = ST_ETH_HDR;
            ST_ETH_HDR:   if (!pkt_en) state_d = ST_IDLE;
                          else if (eth_last) state_d = eth_bad ? ST_DROP : ST_ECPRI_HDR;
            ST_ECPRI_HDR: if (!pkt_en) state_d = ST_IDLE;
                          else if (rev_bad || len_bad) state_d = ST_DROP;
                          else if (ec_last) begin
                              if (is_iq)                 state_d = ST_IQ_HDR;
                              else if (size_now == 16'd0) state_d = ST_DROP;
                              else                       state_d = ST_PAYLOAD;
                          end
            ST_IQ_HDR:    if (!pkt_en) state_d = ST_IDLE;
                          else if (iq_last) state_d = (size_q == IQ_HDR_BYTES) ? ST_DROP : ST_PAYLOAD;
            ST_PAYLOAD:   if (!pkt_en) state_d = ST_IDLE;
                          else if (pl_last) state_d = ST_DROP;
            ST_DROP:      if (!pkt_en) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        blocked_d  = blocked_q && pkt_en;
        cnt_d      = cnt_q;
        len_d      = len_q;
        size_d     = size_q;
        pc_id_d    = pc_id_q;
        seq_id_d   = seq_id_q;
        etype_hi_d = etype_hi_q;
        msg_type_d = msg_type_q;
        rev_d      = rev_q;
        concat_d   = concat_q;
        bad_eth_d  = bad_eth_q | eth_bad;
        bad_rev_d  = bad_rev_q | rev_bad;
        bad_len_d  = bad_len_q | len_bad;

        if (start) begin
            cnt_d     = 16'd1;
            pc_id_d   = 16'd0;
            seq_id_d  = 16'd0;
            bad_eth_d = 1'b0;
            bad_rev_d = 1'b0;
            bad_len_d = 1'b0;
        end else if (state_d != state_q) begin
            cnt_d = 16'd0;
        end else if (in_frame && state_q != ST_DROP) begin
            cnt_d = cnt_q + 16'd1;
        end

        if (in_frame && state_q == ST_ETH_HDR && cnt_q == ETH_HDR_LAST - 16'd1)
            etype_hi_d = pkt_data;
        if (in_frame && state_q == ST_ECPRI_HDR) begin
            case (cnt_q[1:0])
                2'd0:    begin rev_d = pkt_data[7:4]; concat_d = pkt_data[0]; end
                2'd1:    msg_type_d = pkt_data;
                2'd2:    size_d[15:8] = pkt_data;
                default: size_d = size_now;
            endcase
        end
        if (in_frame && state_q == ST_IQ_HDR) begin
            case (cnt_q[1:0])
                2'd0:    pc_id_d[15:8]  = pkt_data;
                2'd1:    pc_id_d[7:0]   = pkt_data;
                2'd2:    seq_id_d[15:8] = pkt_data;
                default: seq_id_d[7:0]  = pkt_data;
            endcase
        end
        if (ec_last) len_d = size_now;
        if (iq_last) len_d = size_q - IQ_HDR_BYTES;

        hdr_valid_d = (ec_last && !is_iq) || iq_last;
        pl_valid_d  = pl_byte;
        pl_data_d   = pl_byte ? pkt_data : 8'h00;
        pl_sop_d    = pl_byte && (cnt_q == 16'd0);
        pl_eop_d    = pl_last;
        frm_done_d  = fall;
        err_eth_d   = fall && bad_eth_q;
        err_rev_d   = fall && bad_rev_q;
        err_len_d   = fall && bad_len_q;
        err_short_d = fall && incomplete;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blocked_q   <= 1'b1;
            cnt_q       <= 16'd0;
            len_q       <= 16'd0;
            size_q      <= 16'd0;
            pc_id_q     <= 16'd0;
            seq_id_q    <= 16'd0;
            etype_hi_q  <= 8'd0;
            msg_type_q  <= 8'd0;
            rev_q       <= 4'd0;
            concat_q    <= 1'b0;
            bad_eth_q   <= 1'b0;
            bad_rev_q   <= 1'b0;
            bad_len_q   <= 1'b0;
            hdr_valid_q <= 1'b0;
            pl_valid_q  <= 1'b0;
            pl_data_q   <= 8'd0;
            pl_sop_q    <= 1'b0;
            pl_eop_q    <= 1'b0;
            frm_done_q  <= 1'b0;
            err_eth_q   <= 1'b0;
            err_rev_q   <= 1'b0;
            err_len_q   <= 1'b0;
            err_short_q <= 1'b0;
        end else begin
            blocked_q   <= blocked_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            size_q      <= size_d;
            pc_id_q     <= pc_id_d;
            seq_id_q    <= seq_id_d;
            etype_hi_q  <= etype_hi_d;
            msg_type_q  <= msg_type_d;
            rev_q       <= rev_d;
            concat_q    <= concat_d;
            bad_eth_q   <= bad_eth_d;
            bad_rev_q   <= bad_rev_d;
            bad_len_q   <= bad_len_d;
            hdr_valid_q <= hdr_valid_d;
            pl_valid_q  <= pl_valid_d;
            pl_data_q   <= pl_data_d;
            pl_sop_q    <= pl_sop_d;
            pl_eop_q    <= pl_eop_d;
            frm_done_q  <= frm_done_d;
            err_eth_q   <= err_eth_d;
            err_rev_q   <= err_rev_d;
            err_len_q   <= err_len_d;
            err_short_q <= err_short_d;
        end
    end

    assign hdr_valid        = hdr_valid_q;
    assign hdr_revision     = rev_q;
    assign hdr_concat       = concat_q;
    assign hdr_msg_type     = msg_type_q;
    assign hdr_payload_size = size_q;
    assign hdr_pc_id        = pc_id_q;
    assign hdr_seq_id       = seq_id_q;
    assign pl_valid         = pl_valid_q;
    assign pl_data          = pl_data_q;
    assign pl_sop           = pl_sop_q;
    assign pl_eop           = pl_eop_q;
    assign frm_done         = frm_done_q;
    assign err_ethertype    = err_eth_q;
    assign err_revision     = err_rev_q;
    assign err_length       = err_len_q;
    assign err_short        = err_short_q;

`ifdef ECPRI_RX_STATS_EN
    ecpri_rx_stats u_stats (
        .clk       (clk),
        .rst_n     (rst_n),
        .frm_done  (frm_done_q),
        .frm_err   (err_eth_q | err_rev_q | err_len_q | err_short_q),
        .stat_good (stat_good),
        .stat_bad  (stat_bad)
    );
`endif

endmodule

// File: tb/tb_ecpri_rx_parser.sv
// Bench for ecpri_rx_parser: directed spec scenarios plus randomized frames against a frame-level model.
module tb_ecpri_rx_parser;

    logic        clk = 1'b0;
    logic        rst_n, pkt_en;
    logic [7:0]  pkt_data;
    logic        hdr_valid, hdr_concat, pl_valid, pl_sop, pl_eop, frm_done;
    logic [3:0]  hdr_revision;
    logic [7:0]  hdr_msg_type, pl_data;
    logic [15:0] hdr_payload_size, hdr_pc_id, hdr_seq_id;
    logic        err_ethertype, err_revision, err_length, err_short;
`ifdef ECPRI_RX_STATS_EN
    logic [31:0] stat_good, stat_bad;
`endif
    logic [77:0] all_out;

    always #5 clk = ~clk;

    ecpri_rx_parser dut (
        .clk(clk), .rst_n(rst_n), .pkt_en(pkt_en), .pkt_data(pkt_data),
        .hdr_valid(hdr_valid), .hdr_revision(hdr_revision), .hdr_concat(hdr_concat),
        .hdr_msg_type(hdr_msg_type), .hdr_payload_size(hdr_payload_size),
        .hdr_pc_id(hdr_pc_id), .hdr_seq_id(hdr_seq_id),
        .pl_valid(pl_valid), .pl_data(pl_data), .pl_sop(pl_sop), .pl_eop(pl_eop),
        .frm_done(frm_done), .err_ethertype(err_ethertype), .err_revision(err_revision),
        .err_length(err_length), .err_short(err_short)
`ifdef ECPRI_RX_STATS_EN
        , .stat_good(stat_good), .stat_bad(stat_bad)
`endif
    );

    assign all_out = {hdr_valid, hdr_revision, hdr_concat, hdr_msg_type, hdr_payload_size,
                      hdr_pc_id, hdr_seq_id, pl_valid, pl_data, pl_sop, pl_eop,
                      frm_done, err_ethertype, err_revision, err_length, err_short};

    typedef struct packed {
        logic [3:0] rev; logic c; logic [7:0] typ; logic [15:0] size; logic [15:0] pc; logic [15:0] seq;
    } hdr_ev_t;
    typedef struct packed { logic [7:0] d; logic sop; logic eop; } pl_ev_t;
    typedef struct packed { logic e; logic r; logic l; logic s; } done_ev_t;

    hdr_ev_t     mon_hdr[$], exp_hdr[$];
    pl_ev_t      mon_pl[$],  exp_pl[$];
    done_ev_t    mon_done[$], exp_done[$];
    logic [7:0]  frm[$];
    int          checks = 0, passes = 0, viol = 0;
    int unsigned exp_good = 0, exp_bad = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (hdr_valid) mon_hdr.push_back(hdr_ev_t'({hdr_revision, hdr_concat, hdr_msg_type,
                                                        hdr_payload_size, hdr_pc_id, hdr_seq_id}));
            if (pl_valid)  mon_pl.push_back(pl_ev_t'({pl_data, pl_sop, pl_eop}));
            if (frm_done)  mon_done.push_back(done_ev_t'({err_ethertype, err_revision, err_length, err_short}));
            if (!frm_done && (err_ethertype || err_revision || err_length || err_short)) viol++;
            if (!pl_valid && (pl_sop || pl_eop)) viol++;
        end
    end

    // Frame-level reference: walks the byte list with the protocol's rules, no cycle model.
    task automatic model_frame();
        int n = frm.size();
        int hl, plen;
        logic iq;
        logic [7:0] typ;
        logic [15:0] size;
        done_ev_t d = '0;
        if (n < 14) d.s = 1'b1;
        else if ({frm[12], frm[13]} != 16'hAEFE) d.e = 1'b1;
        else if (n < 15) d.s = 1'b1;
        else if (frm[14][7:4] != 4'd1) d.r = 1'b1;
        else if (n < 18) d.s = 1'b1;
        else begin
            typ  = frm[15];
            size = {frm[16], frm[17]};
            iq   = (typ <= 8'd2);
            if (iq && size < 16'd4) d.l = 1'b1;
            else begin
                hl = iq ? 22 : 18;
                if (n < hl) d.s = 1'b1;
                else begin
                    plen = iq ? int'(size) - 4 : int'(size);
                    exp_hdr.push_back(hdr_ev_t'({frm[14][7:4], frm[14][0], typ, size,
                                                 iq ? {frm[18], frm[19]} : 16'h0000,
                                                 iq ? {frm[20], frm[21]} : 16'h0000}));
                    for (int i = 0; i < plen && hl + i < n; i++)
                        exp_pl.push_back(pl_ev_t'({frm[hl+i], i == 0, i == plen - 1}));
                    if (n < hl + plen) d.s = 1'b1;
                end
            end
        end
        exp_done.push_back(d);
        if (d == 4'b0000) exp_good++; else exp_bad++;
    endtask

    task automatic build(input logic [15:0] et, input logic [3:0] rev, input logic c,
                         input logic [7:0] typ, input logic [15:0] size, input logic [15:0] pc,
                         input logic [15:0] seq, input int npl, input int npad, input bit ramp);
        frm.delete();
        for (int i = 0; i < 12; i++) frm.push_back(8'($urandom));
        frm.push_back(et[15:8]);  frm.push_back(et[7:0]);
        frm.push_back({rev, 3'($urandom), c});
        frm.push_back(typ);
        frm.push_back(size[15:8]); frm.push_back(size[7:0]);
        if (typ <= 8'd2) begin
            frm.push_back(pc[15:8]);  frm.push_back(pc[7:0]);
            frm.push_back(seq[15:8]); frm.push_back(seq[7:0]);
        end
        for (int i = 0; i < npl; i++)  frm.push_back(ramp ? 8'(i) : 8'($urandom));
        for (int i = 0; i < npad; i++) frm.push_back(8'($urandom));
    endtask

    task automatic send_bytes(input int from, input int to);
        for (int i = from; i < to; i++) begin
            @(posedge clk); #1;
            pkt_en = 1'b1; pkt_data = frm[i];
        end
    endtask

    task automatic end_frame(input int gap);
        @(posedge clk); #1;
        pkt_en = 1'b0; pkt_data = 8'h00;
        repeat (gap - 1) @(posedge clk);
    endtask

    task automatic send_frame(input int gap);
        model_frame();
        send_bytes(0, frm.size());
        end_frame(gap);
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic flush();
        mon_hdr.delete(); mon_pl.delete(); mon_done.delete();
        exp_hdr.delete(); exp_pl.delete(); exp_done.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pkt_en = 1'b0; pkt_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (all_out !== '0) $display("FAIL reset_outputs: got %h want 0", all_out); else passes++;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (all_out !== '0) $display("FAIL idle_outputs: got %h want 0", all_out); else passes++;
`ifdef ECPRI_RX_STATS_EN
        checks++; if (stat_good !== 32'd0 || stat_bad !== 32'd0)
            $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_good, stat_bad); else passes++;
`endif
    endtask

    task automatic test_valid_iq();
        flush();
        build(16'hAEFE, 4'd1, 1'b0, 8'd0, 16'h0014, 16'h1234, 16'h5600, 16, 4, 1'b1);
        send_frame(2); settle();
        checks++; if (mon_hdr.size() !== 1) $display("FAIL iq_hdr_count: got %0d want 1", mon_hdr.size()); else passes++;
        if (mon_hdr.size() > 0) begin
            checks++;
            if (mon_hdr[0] !== hdr_ev_t'({4'd1, 1'b0, 8'd0, 16'h0014, 16'h1234, 16'h5600}))
                $display("FAIL iq_hdr_fields: got %h want %h", mon_hdr[0],
                         hdr_ev_t'({4'd1, 1'b0, 8'd0, 16'h0014, 16'h1234, 16'h5600}));
            else passes++;
        end
        checks++; if (mon_pl.size() !== 16) $display("FAIL iq_pl_count: got %0d want 16", mon_pl.size()); else passes++;
        for (int i = 0; i < mon_pl.size() && i < 16; i++) begin
            checks++;
            if (mon_pl[i] !== pl_ev_t'({8'(i), i == 0, i == 15}))
                $display("FAIL iq_pl_byte[%0d]: got %h want %h", i, mon_pl[i], pl_ev_t'({8'(i), i == 0, i == 15}));
            else passes++;
        end
        checks++; if (mon_done.size() !== 1) $display("FAIL iq_done_count: got %0d want 1", mon_done.size()); else passes++;
        if (mon_done.size() > 0) begin
            checks++; if (mon_done[0] !== 4'b0000) $display("FAIL iq_done_flags: got %b want 0000", mon_done[0]); else passes++;
        end
    endtask

    task automatic test_hdr_errors();
        logic [15:0] et, size;
        logic [3:0]  rev, want;
        for (int k = 0; k < 3; k++) begin
            flush();
            et   = (k == 0) ? 16'h0800 : 16'hAEFE;
            rev  = (k == 1) ? 4'd2 : 4'd1;
            size = (k == 2) ? 16'h0002 : 16'h0014;
            want = 4'b1000 >> k;
            build(et, rev, 1'b0, 8'd0, size, 16'h1111, 16'h2222, 16, 4, 1'b0);
            send_frame(2); settle();
            checks++; if (mon_hdr.size() !== 0) $display("FAIL err%0d_hdr_count: got %0d want 0", k, mon_hdr.size()); else passes++;
            checks++; if (mon_pl.size() !== 0) $display("FAIL err%0d_pl_count: got %0d want 0", k, mon_pl.size()); else passes++;
            checks++; if (mon_done.size() !== 1) $display("FAIL err%0d_done_count: got %0d want 1", k, mon_done.size()); else passes++;
            if (mon_done.size() > 0) begin
                checks++; if (mon_done[0] !== want) $display("FAIL err%0d_flags: got %b want %b", k, mon_done[0], want); else passes++;
            end
        end
    endtask

    task automatic test_truncated();
        int eops = 0;
        flush();
        build(16'hAEFE, 4'd1, 1'b0, 8'd0, 16'h0020, 16'hABCD, 16'h0001, 28, 0, 1'b1);
        frm = frm[0:31];
        send_frame(2); settle();
        checks++; if (mon_pl.size() !== 10) $display("FAIL trunc_pl_count: got %0d want 10", mon_pl.size()); else passes++;
        foreach (mon_pl[i]) if (mon_pl[i].eop) eops++;
        checks++; if (eops !== 0) $display("FAIL trunc_eop: got %0d want 0", eops); else passes++;
        checks++; if (mon_done.size() !== 1) $display("FAIL trunc_done_count: got %0d want 1", mon_done.size()); else passes++;
        if (mon_done.size() > 0) begin
            checks++; if (mon_done[0] !== 4'b0001) $display("FAIL trunc_flags: got %b want 0001", mon_done[0]); else passes++;
        end
    endtask

    task automatic test_back_to_back();
        flush();
        build(16'hAEFE, 4'd1, 1'b0, 8'd0, 16'h0014, 16'h1234, 16'h5600, 16, 4, 1'b1);
        send_frame(1);
        build(16'hAEFE, 4'd1, 1'b1, 8'd5, 16'h0003, 16'h9999, 16'h9999, 3, 6, 1'b1);
        send_frame(2); settle();
        checks++; if (mon_hdr.size() !== 2) $display("FAIL b2b_hdr_count: got %0d want 2", mon_hdr.size()); else passes++;
        if (mon_hdr.size() > 1) begin
            checks++;
            if (mon_hdr[1] !== hdr_ev_t'({4'd1, 1'b1, 8'd5, 16'd3, 16'd0, 16'd0}))
                $display("FAIL b2b_hdr2: got %h want %h", mon_hdr[1], hdr_ev_t'({4'd1, 1'b1, 8'd5, 16'd3, 16'd0, 16'd0}));
            else passes++;
        end
        checks++; if (mon_pl.size() !== 19) $display("FAIL b2b_pl_count: got %0d want 19", mon_pl.size()); else passes++;
        if (mon_pl.size() == 19) begin
            checks++;
            if ({mon_pl[16].sop, mon_pl[18].eop, mon_pl[17].sop, mon_pl[17].eop} !== 4'b1100)
                $display("FAIL b2b_sop_eop: got %b want 1100",
                         {mon_pl[16].sop, mon_pl[18].eop, mon_pl[17].sop, mon_pl[17].eop});
            else passes++;
        end
        checks++;
        if (mon_done.size() !== 2 || mon_done[0] !== 4'b0000 || mon_done[1] !== 4'b0000)
            $display("FAIL b2b_done: got count %0d want 2 clean", mon_done.size());
        else passes++;
    endtask

    task automatic test_reset_mid_frame();
        flush();
        build(16'hAEFE, 4'd1, 1'b0, 8'd0, 16'h0014, 16'h1234, 16'h5600, 16, 4, 1'b1);
        send_bytes(0, 28);
        @(posedge clk); #1;
        rst_n = 1'b0; pkt_data = frm[28];
        exp_good = 0; exp_bad = 0;
        @(negedge clk);
        checks++; if (all_out !== '0) $display("FAIL midrst_outputs: got %h want 0", all_out); else passes++;
        @(posedge clk); #1;
        rst_n = 1'b1; pkt_data = frm[29];
        flush();
        send_bytes(30, frm.size());
        end_frame(2); settle();
        checks++;
        if (mon_hdr.size() + mon_pl.size() + mon_done.size() !== 0)
            $display("FAIL midrst_ignored: got %0d events want 0", mon_hdr.size() + mon_pl.size() + mon_done.size());
        else passes++;
        build(16'hAEFE, 4'd1, 1'b0, 8'd1, 16'h0008, 16'h4321, 16'h0007, 4, 2, 1'b0);
        send_frame(2); settle();
        checks++; if (mon_hdr.size() !== 1 || exp_hdr.size() !== 1 || mon_hdr[0] !== exp_hdr[0])
            $display("FAIL midrst_next_hdr: got %0d headers want 1 matching", mon_hdr.size()); else passes++;
        checks++; if (mon_pl.size() !== 4) $display("FAIL midrst_next_pl: got %0d want 4", mon_pl.size()); else passes++;
        checks++; if (mon_done.size() !== 1 || mon_done[0] !== 4'b0000)
            $display("FAIL midrst_next_done: got count %0d want 1 clean", mon_done.size()); else passes++;
`ifdef ECPRI_RX_STATS_EN
        checks++; if (stat_good !== exp_good || stat_bad !== exp_bad)
            $display("FAIL midrst_stats: got %0d/%0d want %0d/%0d", stat_good, stat_bad, exp_good, exp_bad); else passes++;
`endif
    endtask

    task automatic test_random();
        logic [7:0]  typ;
        logic [15:0] size, et;
        logic [3:0]  rev;
        int plen, len;
        for (int it = 0; it < 60; it++) begin
            flush();
            et   = ($urandom_range(0, 9) == 0) ? 16'h88F7 : 16'hAEFE;
            rev  = ($urandom_range(0, 9) == 0) ? 4'd2 : 4'd1;
            typ  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 2)) : 8'($urandom_range(3, 255));
            size = (typ <= 8'd2) ? 16'($urandom_range(0, 24)) : 16'($urandom_range(0, 20));
            plen = (typ <= 8'd2) ? ((size >= 16'd4) ? int'(size) - 4 : 0) : int'(size);
            build(et, rev, 1'($urandom), typ, size, 16'($urandom), 16'($urandom), plen, $urandom_range(0, 5), 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                len = $urandom_range(1, frm.size() - 1);
                frm = frm[0:len-1];
            end
            send_frame($urandom_range(1, 3)); settle();
            checks++; if (mon_hdr.size() !== exp_hdr.size())
                $display("FAIL rnd%0d_hdr_count: got %0d want %0d", it, mon_hdr.size(), exp_hdr.size()); else passes++;
            for (int i = 0; i < mon_hdr.size() && i < exp_hdr.size(); i++) begin
                checks++; if (mon_hdr[i] !== exp_hdr[i])
                    $display("FAIL rnd%0d_hdr: got %h want %h", it, mon_hdr[i], exp_hdr[i]); else passes++;
            end
            checks++; if (mon_pl.size() !== exp_pl.size())
                $display("FAIL rnd%0d_pl_count: got %0d want %0d", it, mon_pl.size(), exp_pl.size()); else passes++;
            for (int i = 0; i < mon_pl.size() && i < exp_pl.size(); i++) begin
                checks++; if (mon_pl[i] !== exp_pl[i])
                    $display("FAIL rnd%0d_pl[%0d]: got %h want %h", it, i, mon_pl[i], exp_pl[i]); else passes++;
            end
            checks++; if (mon_done.size() !== 1 || mon_done[0] !== exp_done[0])
                $display("FAIL rnd%0d_done: got count %0d flags %b want 1 flags %b", it, mon_done.size(),
                         (mon_done.size() > 0) ? mon_done[0] : 4'bxxxx, exp_done[0]); else passes++;
        end
`ifdef ECPRI_RX_STATS_EN
        checks++; if (stat_good !== exp_good || stat_bad !== exp_bad)
            $display("FAIL rnd_stats: got %0d/%0d want %0d/%0d", stat_good, stat_bad, exp_good, exp_bad); else passes++;
`endif
    endtask

    task automatic test_flag_qualification();
        checks++; if (viol !== 0) $display("FAIL unqualified_flags: got %0d cycles want 0", viol); else passes++;
    endtask

    initial begin
        test_reset();
        test_valid_iq();
        test_hdr_errors();
        test_truncated();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        test_flag_qualification();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
